// File: rtl/base4_divider.sv
// Iterative radix-4 restoring unsigned divider: two quotient bits per cycle, WIDTH/2 steps.
// One division in flight; a start is accepted in IDLE or in the result cycle (DONE).
module base4_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             input_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             output_valid
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             step;
  logic             finish;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work;   // dividend bits shift out the top, quotient digits shift in the bottom
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] pr;

  logic [WIDTH+1:0] pr_ext;
  logic [WIDTH+1:0] d1;
  logic [WIDTH+1:0] d2;
  logic [WIDTH+1:0] d3;
  logic [WIDTH+1:0] sub;
  logic [1:0]       digit;
  logic [WIDTH-1:0] pr_nxt;
  logic [WIDTH-1:0] work_nxt;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (input_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (input_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One radix-4 restoring step. A zero divisor makes every multiple zero, so each
  // digit is 3 and the partial remainder just accumulates the dividend: this yields
  // q = all ones, r = dividend without any special casing.
  always_comb begin
    pr_ext = {pr, work[WIDTH-1:WIDTH-2]};
    d1     = {2'b00, dvsr};
    d2     = {1'b0, dvsr, 1'b0};
    d3     = d1 + d2;
    digit  = 2'd0;
    sub    = '0;
    if (pr_ext >= d3) begin
      digit = 2'd3;
      sub   = d3;
    end else if (pr_ext >= d2) begin
      digit = 2'd2;
      sub   = d2;
    end else if (pr_ext >= d1) begin
      digit = 2'd1;
      sub   = d1;
    end
    pr_nxt   = WIDTH'(pr_ext - sub);
    work_nxt = {work[WIDTH-3:0], digit};
  end

  // Working registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      work <= '0;
      dvsr <= '0;
      pr   <= '0;
      cnt  <= '0;
    end else if (accept) begin
      work <= dividend;
      dvsr <= divisor;
      pr   <= '0;
      cnt  <= '0;
    end else if (step) begin
      work <= work_nxt;
      pr   <= pr_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  // Results are held until the next division completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quotient     <= '0;
      remainder    <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= finish;
      if (finish) begin
        quotient  <= work_nxt;
        remainder <= pr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_base4_divider.sv
// Self-checking bench for base4_divider: directed vectors, busy/reset corners, random back-to-back sweep.
module tb_base4_divider;

  localparam int W       = 32;
  localparam int LAT     = W / 2;
  localparam int TIMEOUT = 40;
  localparam int NRAND   = 2000;

  logic         clk;
  logic         rstn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         input_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         output_valid;

  int checks;
  int errors;

  base4_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .dividend     (dividend),
    .divisor      (divisor),
    .input_valid  (input_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .output_valid (output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a start for one edge; returns at edge+1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend    = a;
    divisor     = b;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  // Count edges until output_valid is seen (sampled 1 after each edge).
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
      if (output_valid) return;
    end
  endtask

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic logic [W-1:0] log_rand();
    logic [W-1:0] v;
    v = $urandom;
    return v >> $urandom_range(0, W - 1);
  endfunction

  initial begin
    int lat;
    logic [W-1:0] a, b, ea, eb;
    bit seen;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[2] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          32'd0};
    vecs[3] = '{32'd5,          32'h8000_0000,  32'd0,          32'd5};
    vecs[4] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF};
    vecs[5] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234};
    vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[7] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};
    vecs[8] = '{32'd1000,       32'd3,          32'd333,        32'd1};
    vecs[9] = '{32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  32'h0000_BEEF};

    rstn        = 1'b0;
    dividend    = '0;
    divisor     = '0;
    input_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, output_valid}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors, each followed by a pulse-width and hold check
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(0, lat);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_q", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_r", i), remainder, vecs[i].r);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pulse_end", i), {31'd0, output_valid}, 32'd0);
      check($sformatf("vec%0d_hold_q", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_hold_r", i), remainder, vecs[i].r);
      repeat (2) @(posedge clk);
      #1;
    end

    // Start while busy must be ignored
    issue(32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    issue(32'd5, 32'd1);
    wait_done(3, lat);
    check("busy_ignore_latency", lat, LAT);
    check("busy_ignore_q", quotient, 32'd14);
    check("busy_ignore_r", remainder, 32'd2);
    repeat (4) @(posedge clk);
    #1;
    check("busy_ignore_no_second", {31'd0, output_valid}, 32'd0);

    // Reset in the middle of a division aborts it
    issue(32'd1000, 32'd3);
    repeat (7) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (output_valid) seen = 1'b1;
    end
    check("midrst_no_pulse", {31'd0, seen}, 32'd0);
    check("midrst_q_after", quotient, 32'd0);
    check("midrst_r_after", remainder, 32'd0);
    issue(32'd9, 32'd2);
    wait_done(0, lat);
    check("after_rst_latency", lat, LAT);
    check("after_rst_q", quotient, 32'd4);
    check("after_rst_r", remainder, 32'd1);

    // Random back-to-back sweep: next start issued in each result cycle
    @(negedge clk);
    a = log_rand();
    b = log_rand();
    issue(a, b);
    for (int n = 0; n < NRAND; n++) begin
      ea = ref_q(a, b);
      eb = ref_r(a, b);
      wait_done(0, lat);
      check($sformatf("rand%0d_latency", n), lat, LAT);
      check($sformatf("rand%0d_q %0d/%0d", n, a, b), quotient, ea);
      check($sformatf("rand%0d_r %0d/%0d", n, a, b), remainder, eb);
      if (n < NRAND - 1) begin
        a = log_rand();
        b = ($urandom_range(0, 31) == 0) ? '0 : log_rand();
        issue(a, b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
